// File: rtl/sid_multi_regs_pkg.sv
// rtl/sid_multi_regs_pkg.sv - shared constants and helpers for the SID register front-end
package sid_multi_regs_pkg;

    localparam int NUM_REGS = 25;
    localparam int REG_W    = 8;

    localparam logic [4:0] SID_V1_FREQ_LO = 5'h00;
    localparam logic [4:0] SID_V1_FREQ_HI = 5'h01;
    localparam logic [4:0] SID_V1_PW_LO   = 5'h02;
    localparam logic [4:0] SID_V1_PW_HI   = 5'h03;
    localparam logic [4:0] SID_V1_CTRL    = 5'h04;
    localparam logic [4:0] SID_V1_AD      = 5'h05;
    localparam logic [4:0] SID_V1_SR      = 5'h06;
    localparam logic [4:0] SID_V2_FREQ_LO = 5'h07;
    localparam logic [4:0] SID_V2_FREQ_HI = 5'h08;
    localparam logic [4:0] SID_V2_PW_LO   = 5'h09;
    localparam logic [4:0] SID_V2_PW_HI   = 5'h0A;
    localparam logic [4:0] SID_V2_CTRL    = 5'h0B;
    localparam logic [4:0] SID_V2_AD      = 5'h0C;
    localparam logic [4:0] SID_V2_SR      = 5'h0D;
    localparam logic [4:0] SID_V3_FREQ_LO = 5'h0E;
    localparam logic [4:0] SID_V3_FREQ_HI = 5'h0F;
    localparam logic [4:0] SID_V3_PW_LO   = 5'h10;
    localparam logic [4:0] SID_V3_PW_HI   = 5'h11;
    localparam logic [4:0] SID_V3_CTRL    = 5'h12;
    localparam logic [4:0] SID_V3_AD      = 5'h13;
    localparam logic [4:0] SID_V3_SR      = 5'h14;
    localparam logic [4:0] SID_FC_LO      = 5'h15;
    localparam logic [4:0] SID_FC_HI      = 5'h16;
    localparam logic [4:0] SID_RES_FILT   = 5'h17;
    localparam logic [4:0] SID_MODE_VOL   = 5'h18;
    localparam logic [4:0] SID_POTX       = 5'h19;
    localparam logic [4:0] SID_POTY       = 5'h1A;
    localparam logic [4:0] SID_OSC3       = 5'h1B;
    localparam logic [4:0] SID_ENV3       = 5'h1C;

    localparam logic [3:0] PW_HI_MASK = 4'hF;

    // Pulse-width high registers only implement their low nibble.
    function automatic logic is_pw_hi(input logic [4:0] a);
        return (a == SID_V1_PW_HI) || (a == SID_V2_PW_HI) || (a == SID_V3_PW_HI);
    endfunction

endpackage

// File: rtl/sid_multi_regs_if.sv
// rtl/sid_multi_regs_if.sv - shared CPU-side bus for all SID chips
interface sid_multi_regs_if #(
    parameter int NUM_SID = 2
);
    logic [NUM_SID-1:0] cs;
    logic               we;
    logic               rd;
    logic [4:0]         addr;
    logic [7:0]         data_in;
    logic [7:0]         data_out;

    modport master (output cs, output we, output rd, output addr, output data_in, input data_out);
    modport slave  (input cs, input we, input rd, input addr, input data_in, output data_out);
endinterface

// File: rtl/sid_multi_regs_bus_latch.sv
// rtl/sid_multi_regs_bus_latch.sv - per-chip data-bus latch with leakage decay
module sid_bus_latch #(
    parameter int DECAY_TICKS = 8000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce_1m,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic [7:0] o_latch
);
    localparam int CNT_W = (DECAY_TICKS > 0) ? $clog2(DECAY_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DECAY_TICKS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_latch;

    // Load beats decay; with DECAY_TICKS = 0 the counter stays 0 so the latch never leaks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_latch <= '0;
        end else if (i_load) begin
            r_cnt   <= LOAD_VAL;
            r_latch <= i_data;
        end else if (i_ce_1m) begin
            if (r_cnt > ONE) begin
                r_cnt <= r_cnt - ONE;
            end else if (r_cnt == ONE) begin
                r_cnt   <= '0;
                r_latch <= '0;
            end
        end
    end

    assign o_latch = r_latch;
endmodule

// File: rtl/sid_multi_regs.sv
// rtl/sid_multi_regs.sv - multi-chip SID register file, write decode and read mux
module sid_multi_regs
    import sid_multi_regs_pkg::*;
#(
    parameter int NUM_SID     = 2,
    parameter int DECAY_TICKS = 8000
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_ce_1m,
    sid_multi_regs_if.slave                  bus,
    input  logic [8*NUM_SID-1:0]             i_pot_x,
    input  logic [8*NUM_SID-1:0]             i_pot_y,
    input  logic [8*NUM_SID-1:0]             i_osc3,
    input  logic [8*NUM_SID-1:0]             i_env3,
    output logic [NUM_REGS*REG_W*NUM_SID-1:0] o_regs,
    output logic [3*NUM_SID-1:0]             o_ctrl_wr
);
    localparam int CHIP_W = NUM_REGS * REG_W;

    logic                    w_addr_in_file;
    logic                    w_addr_readback;
    logic [NUM_SID-1:0]      w_wr;
    logic [NUM_SID-1:0]      w_refresh;
    logic [NUM_SID-1:0]      w_load;
    logic [NUM_SID-1:0][7:0] w_readback;
    logic [NUM_SID-1:0][7:0] w_latch;
    logic [NUM_SID-1:0][7:0] w_load_data;

    assign w_addr_in_file  = (bus.addr <= SID_MODE_VOL);
    assign w_addr_readback = (bus.addr >= SID_POTX) && (bus.addr <= SID_ENV3);

    genvar g, r;
    generate
        for (g = 0; g < NUM_SID; g++) begin : g_chip
            logic [REG_W-1:0] r_file [NUM_REGS];
            logic [2:0]       r_ctrl_wr;

            // Writes are broadcast to every selected chip; a simultaneous read never refreshes.
            assign w_wr[g]      = bus.we & bus.cs[g];
            assign w_refresh[g] = ~bus.we & bus.rd & bus.cs[g] & w_addr_readback;
            assign w_load[g]    = w_wr[g] | w_refresh[g];

            assign w_readback[g] = (bus.addr == SID_POTX) ? i_pot_x[8*g +: 8] :
                                   (bus.addr == SID_POTY) ? i_pot_y[8*g +: 8] :
                                   (bus.addr == SID_OSC3) ? i_osc3[8*g +: 8]  :
                                   (bus.addr == SID_ENV3) ? i_env3[8*g +: 8]  :
                                                            w_latch[g];

            assign w_load_data[g] = bus.we ? bus.data_in : w_readback[g];

            sid_bus_latch #(
                .DECAY_TICKS (DECAY_TICKS)
            ) u_bus_latch (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_ce_1m (i_ce_1m),
                .i_load  (w_load[g]),
                .i_data  (w_load_data[g]),
                .o_latch (w_latch[g])
            );

            // Register file update; pulse-width high keeps only its low nibble.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        r_file[k] <= '0;
                    end
                end else if (w_wr[g] && w_addr_in_file) begin
                    if (is_pw_hi(bus.addr)) begin
                        r_file[bus.addr] <= {4'h0, bus.data_in[3:0] & PW_HI_MASK};
                    end else begin
                        r_file[bus.addr] <= bus.data_in;
                    end
                end
            end

            // One-clock pulse per voice control register write.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_ctrl_wr <= '0;
                end else begin
                    r_ctrl_wr <= {w_wr[g] && (bus.addr == SID_V3_CTRL),
                                  w_wr[g] && (bus.addr == SID_V2_CTRL),
                                  w_wr[g] && (bus.addr == SID_V1_CTRL)};
                end
            end

            assign o_ctrl_wr[3*g +: 3] = r_ctrl_wr;

            for (r = 0; r < NUM_REGS; r++) begin : g_reg
                assign o_regs[CHIP_W*g + REG_W*r +: REG_W] = r_file[r];
            end
        end
    endgenerate

    // Lowest selected chip drives the read bus; nothing selected floats high.
    always_comb begin
        bus.data_out = 8'hFF;
        for (int i = NUM_SID - 1; i >= 0; i--) begin
            if (bus.cs[i]) begin
                bus.data_out = w_readback[i];
            end
        end
    end
endmodule
